// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the combo-lock datapath blocks.
package combo_lock_pkg;

  localparam int DIGW = 4;
  localparam int NDIG = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [DIGW-1:0] digit_t;

endpackage

// File: rtl/code_nibble_serializer_rise_detect.sv
// Single-bit rising-edge detector; the pulse is combinational from the live input.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/code_nibble_serializer.sv
// Loads a code word in one cycle and replays it one digit per trig rising edge,
// first-entered digit first, pulsing done once the last digit is consumed.
module code_nibble_serializer
  import combo_lock_pkg::*;
#(
  parameter  int DIGW = combo_lock_pkg::DIGW,
  parameter  int NDIG = combo_lock_pkg::NDIG,
  localparam int WW   = DIGW * NDIG,
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [WW-1:0]   data,
  input  logic            trig,
  output logic [DIGW-1:0] out,
  output logic            valid,
  output logic            busy,
  output logic [IW-1:0]   idx,
  output logic            done
);

  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] shreg;
  logic          adv;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (trig),
    .rise (adv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DONE is a fixed one-cycle stop; load is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (adv && idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= data;
            idx   <= '0;
          end
        end
        SHIFT: begin
          if (adv) begin
            if (idx == LAST) begin
              shreg <= '0;
              idx   <= '0;
            end else begin
              shreg <= shreg << DIGW;
              idx   <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state so reset clears them without waiting for an edge.
  always_comb begin
    out   = '0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      SHIFT: begin
        out   = shreg[WW-1 -: DIGW];
        valid = 1'b1;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
